// File: rtl/memory_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port synchronous RAM.
// Optional `ROUND_ROBIN_EN alternates the winner on contention; default is fixed ls-over-if priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_err,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_rw,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  state_t                state;
  owner_t                owner;
  logic                  err_q;
  logic                  store_q;
  logic                  ls_first;
  logic                  grant_ls;
  logic                  any_req;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_oor;
  logic                  sel_store;

`ifdef ROUND_ROBIN_EN
  logic last_ls;
  // ls only wins a tie when fetch was the last one served
  assign ls_first = !last_ls;
`else
  assign ls_first = 1'b1;
`endif

  assign any_req   = if_req | ls_req;
  assign grant_ls  = ls_req & (~if_req | ls_first);
  assign sel_addr  = grant_ls ? ls_addr : if_addr;
  assign sel_oor   = (sel_addr >= DEPTH);
  assign sel_store = grant_ls & ls_we;

  // RAM data arrives in the RESP cycle, so read data is gated, not registered
  assign if_rdata = (if_ack && !err_q) ? ram_dout : '0;
  assign ls_rdata = (ls_ack && !err_q && !store_q) ? ram_dout : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      owner   <= OWN_NONE;
      ram_a   <= '0;
      ram_din <= '0;
      ram_rw  <= 1'b0;
      if_ack  <= 1'b0;
      ls_ack  <= 1'b0;
      if_err  <= 1'b0;
      ls_err  <= 1'b0;
      err_q   <= 1'b0;
      store_q <= 1'b0;
      busy    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_ls <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
          if_err <= 1'b0;
          ls_err <= 1'b0;
          if (any_req) begin
            state   <= S_ISSUE;
            owner   <= grant_ls ? OWN_LS : OWN_IF;
            ram_a   <= sel_addr;
            ram_din <= ls_wdata;
            ram_rw  <= sel_store & ~sel_oor;
            err_q   <= sel_oor;
            store_q <= sel_store;
            busy    <= 1'b1;
`ifdef ROUND_ROBIN_EN
            last_ls <= grant_ls;
`endif
          end else begin
            state  <= S_IDLE;
            owner  <= OWN_NONE;
            ram_rw <= 1'b0;
            busy   <= 1'b0;
          end
        end
        S_ISSUE: begin
          state  <= S_RESP;
          ram_rw <= 1'b0;
          if_ack <= (owner == OWN_IF);
          ls_ack <= (owner == OWN_LS);
          if_err <= (owner == OWN_IF) & err_q;
          ls_err <= (owner == OWN_LS) & err_q;
          busy   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, contention / back-to-back / reset
// sequences, then two random requesters checked against a transaction-level memory model.
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_ack, ls_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_rw, busy;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_a(ram_a), .ram_din(ram_din), .ram_rw(ram_rw), .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return (i == 5) ? 32'hE3A01001 : 32'(i) * 32'h9E3779B1;
  endfunction

  // Synchronous single-port RAM; ram_init preloads a known pattern
  logic          ram_init;
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (ram_rw && ram_a < DEPTH) begin
      mem[ram_a[12:0]] <= ram_din;
    end
    ram_dout <= (ram_a < DEPTH) ? mem[ram_a[12:0]] : '0;
  end

  int rw_count = 0;
  int both_ack = 0;
  always @(negedge clk) begin
    if (rst_n && ram_rw) rw_count++;
    if (if_ack && ls_ack) both_ack++;
  end

  logic [DW-1:0] model_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    return (a < DEPTH) ? model_mem[a[12:0]] : '0;
  endfunction

  // All tasks are entered #1 after a rising edge
  task automatic ls_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] rd, output logic er);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (ls_ack) begin
        lat = c; rd = ls_rdata; er = ls_err;
        break;
      end
    end
    ls_req = 1'b0;
  endtask

  task automatic if_access(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] rd,
                           output logic er, output int other);
    if_req = 1'b1; if_addr = a;
    lat = 0; rd = '0; er = 1'b0; other = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (ls_ack) other++;
      if (if_ack) begin
        lat = c; rd = if_rdata; er = if_err;
        break;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_ack"}, 64'(if_ack), 64'd0);
    chk({tag, "_ls_ack"}, 64'(ls_ack), 64'd0);
    chk({tag, "_errs"}, 64'({if_err, ls_err}), 64'd0);
    chk({tag, "_rdata"}, {if_rdata, ls_rdata}, 64'd0);
    chk({tag, "_ram_a"}, 64'(ram_a), 64'd0);
    chk({tag, "_ram_din"}, 64'(ram_din), 64'd0);
    chk({tag, "_ram_rw_busy"}, 64'({ram_rw, busy}), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_rw;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, other, diffs, rw0, if_c, ls_c, k, last, busy_low, bad_period;
    logic [DW-1:0] rd;
    logic er;

    vecs[0] = '{1'b1, 32'h100,      32'hDEADBEEF, 1'b0, 32'h0,        1};
    vecs[1] = '{1'b0, 32'h100,      32'h0,        1'b0, 32'hDEADBEEF, 0};
    vecs[2] = '{1'b1, 32'd8192,     32'h1234,     1'b1, 32'h0,        0};
    vecs[3] = '{1'b0, 32'd8192,     32'h0,        1'b1, 32'h0,        0};
    vecs[4] = '{1'b1, 32'd8191,     32'hA5A5A5A5, 1'b0, 32'h0,        1};
    vecs[5] = '{1'b0, 32'd8191,     32'h0,        1'b0, 32'hA5A5A5A5, 0};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h55AA55AA, 1'b1, 32'h0,        0};
    vecs[7] = '{1'b0, 32'h5,        32'h0,        1'b0, 32'hE3A01001, 0};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);

    rst_n = 1'b0; ram_init = 1'b1;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    ram_init = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch read
    if_access(32'd5, lat, rd, er, other);
    chk("fetch_latency", 64'(lat), 64'd2);
    chk("fetch_rdata", 64'(rd), 64'hE3A01001);
    chk("fetch_err", 64'(er), 64'd0);
    chk("fetch_no_ls_ack", 64'(other), 64'd0);

    // Load/store vector table
    foreach (vecs[i]) begin
      rw0 = rw_count;
      ls_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er);
      if (vecs[i].we && vecs[i].addr < DEPTH) model_mem[vecs[i].addr[12:0]] = vecs[i].wdata;
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ram_rw_cycles", i), 64'(rw_count - rw0), 64'(vecs[i].exp_rw));
    end
    @(posedge clk); #1;
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== model_mem[i]) diffs++;
    chk("ram_readback_diffs", 64'(diffs), 64'd0);

    // Contention from a freshly reset arbiter
    do_reset();
    if_req = 1'b1; if_addr = 32'd1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd2;
    if_c = 0; ls_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if_ack) begin
        if_c = c; if_req = 1'b0;
        chk("contend_if_rdata", 64'(if_rdata), 64'(model_mem[1]));
      end
      if (ls_ack) begin
        ls_c = c; ls_req = 1'b0;
        chk("contend_ls_rdata", 64'(ls_rdata), 64'(model_mem[2]));
      end
      if (if_c != 0 && ls_c != 0) break;
    end
    if_req = 1'b0; ls_req = 1'b0;
`ifdef ROUND_ROBIN_EN
    chk("contend_if_cycle", 64'(if_c), 64'd2);
    chk("contend_ls_cycle", 64'(ls_c), 64'd4);
`else
    chk("contend_ls_cycle", 64'(ls_c), 64'd2);
    chk("contend_if_cycle", 64'(if_c), 64'd4);
`endif

    // Back-to-back fetches, address stepped inside each ack cycle
    @(posedge clk); #1;
    if_addr = '0; if_req = 1'b1;
    k = 0; last = 0; busy_low = 0; bad_period = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (!busy) busy_low++;
      if (if_ack) begin
        chk($sformatf("b2b_rdata%0d", k), 64'(if_rdata), 64'(model_mem[k]));
        if (c - last != 2) bad_period++;
        last = c;
        k++;
        if (k == 8) break;
        if_addr = 32'(k);
      end
    end
    if_req = 1'b0;
    chk("b2b_ack_count", 64'(k), 64'd8);
    chk("b2b_bad_periods", 64'(bad_period), 64'd0);
    chk("b2b_busy_low", 64'(busy_low), 64'd0);

    // Reset asserted during the ISSUE cycle of a fetch
    @(posedge clk); @(posedge clk); #1;
    if_addr = 32'd5; if_req = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy_in_issue", 64'(busy), 64'd1);
    rst_n = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_late_ack", 64'(if_ack), 64'd0);
    if_access(32'd5, lat, rd, er, other);
    chk("midrst_refetch_latency", 64'(lat), 64'd2);
    chk("midrst_refetch_rdata", 64'(rd), 64'hE3A01001);

    // Random traffic from both requesters against the memory model
    both_ack = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [AW-1:0] a;
          int got = 0;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH) + $urandom_range(0, 200) : 32'($urandom_range(0, 31));
          if_addr = a; if_req = 1'b1;
          for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (if_ack) begin got = 1; break; end
          end
          if (got == 0) chk("rand_if_timeout", 64'd0, 64'd1);
          else begin
            chk("rand_if_err", 64'(if_err), 64'(a >= DEPTH));
            chk("rand_if_rdata", 64'(if_rdata), 64'(model_read(a)));
          end
          if_req = 1'b0;
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          logic w;
          int got = 0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
          a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH) + $urandom_range(0, 200) : 32'($urandom_range(0, 31));
          d = $urandom;
          w = 1'($urandom_range(0, 1));
          ls_addr = a; ls_wdata = d; ls_we = w; ls_req = 1'b1;
          for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (ls_ack) begin got = 1; break; end
          end
          if (got == 0) chk("rand_ls_timeout", 64'd0, 64'd1);
          else begin
            chk("rand_ls_err", 64'(ls_err), 64'(a >= DEPTH));
            chk("rand_ls_rdata", 64'(ls_rdata), w ? 64'd0 : 64'(model_read(a)));
            if (w && a < DEPTH) model_mem[a[12:0]] = d;
          end
          ls_req = 1'b0;
        end
      end
    join
    @(posedge clk); #1;
    chk("rand_simultaneous_acks", 64'(both_ack), 64'd0);
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== model_mem[i]) diffs++;
    chk("rand_ram_readback_diffs", 64'(diffs), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
